// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline (D/E/M/W tracking).
// Latency: forward selects come from registered E/M/W state; stall/flush are same-cycle combinational.
// Backpressure: stall holds fetch/decode and turns the execute slot into a bubble for one cycle.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   RsD, RtD, WriteRegD       decode-stage source/destination register addresses
//   RegWriteD, MemtoRegD      decode-stage writes-register / is-load flags
//   BranchD                   decode-stage branch (only used with FWD_DECODE_EN)
//   ForwardAE, ForwardBE      execute operand mux select: 10 = from M, 01 = from W, 00 = register file
//   StallF, StallD, FlushE    pipeline hold / bubble controls
//   StallCount                saturating count of stall cycles
//   ForwardAD, ForwardBD      decode-stage branch compare forwarding (FWD_DECODE_EN builds only)
//
// Optional feature macro: FWD_DECODE_EN (decode-stage branch forwarding and branch stall).
module hazard_forward_unit #(
  parameter int RWL = 5,
  parameter int CWL = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [RWL-1:0] RsD,
  input  logic [RWL-1:0] RtD,
  input  logic [RWL-1:0] WriteRegD,
  input  logic           RegWriteD,
  input  logic           MemtoRegD,
  input  logic           BranchD,
  output logic [1:0]     ForwardAE,
  output logic [1:0]     ForwardBE,
  output logic           StallF,
  output logic           StallD,
  output logic           FlushE,
  output logic [CWL-1:0] StallCount
`ifdef FWD_DECODE_EN
  ,
  output logic           ForwardAD,
  output logic           ForwardBD
`endif
);

  // Pipeline tracking registers
  logic [RWL-1:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic           RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;

  logic lwstall;
  logic stall;

  // M-stage hit wins over W-stage hit; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RWL-1:0] src,
    input logic           rw_m,
    input logic [RWL-1:0] wr_m,
    input logic           rw_w,
    input logic [RWL-1:0] wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rw_m && (wr_m == src))      sel = 2'b10;
      else if (rw_w && (wr_w == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  end

  // A load in E whose destination (Rt) feeds the instruction in D.
  assign lwstall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));

`ifdef FWD_DECODE_EN
  logic branchstall;

  assign ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);

  // The branch compares in decode, so an ALU result still in E or a load
  // still in M cannot be forwarded in time.
  assign branchstall = BranchD &&
                       ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign stall = lwstall || branchstall;
`else
  logic unused_sigs;

  // BranchD and MemtoRegM only matter to decode-stage branch handling.
  assign unused_sigs = BranchD ^ MemtoRegM;
  assign stall       = lwstall;
`endif

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      RsE        <= '0;
      RtE        <= '0;
      WriteRegE  <= '0;
      RegWriteE  <= 1'b0;
      MemtoRegE  <= 1'b0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      WriteRegW  <= '0;
      RegWriteW  <= 1'b0;
      StallCount <= '0;
    end else begin
      WriteRegW <= WriteRegM;
      RegWriteW <= RegWriteM;
      WriteRegM <= WriteRegE;
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      if (FlushE) begin
        // Bubble is a full nop so it can never match a forward compare.
        RsE       <= '0;
        RtE       <= '0;
        WriteRegE <= '0;
        RegWriteE <= 1'b0;
        MemtoRegE <= 1'b0;
      end else begin
        RsE       <= RsD;
        RtE       <= RtD;
        WriteRegE <= WriteRegD;
        RegWriteE <= RegWriteD;
        MemtoRegE <= MemtoRegD;
      end
      if (stall && (StallCount != '1)) begin
        StallCount <= StallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [4:0]  RsD, RtD, WriteRegD;
  logic        RegWriteD, MemtoRegD, BranchD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushE;
  logic [15:0] StallCount;

  // Second instance with a 2-bit counter to observe saturation
  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_fe;
  logic [1:0]  s_cnt;

`ifdef FWD_DECODE_EN
  logic ForwardAD, ForwardBD, s_fad, s_fbd;
`endif

  hazard_forward_unit dut (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .StallCount(StallCount)
`ifdef FWD_DECODE_EN
    , .ForwardAD(ForwardAD), .ForwardBD(ForwardBD)
`endif
  );

  hazard_forward_unit #(.RWL(5), .CWL(2)) dut_sat (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
    .ForwardAE(s_fa), .ForwardBE(s_fb),
    .StallF(s_sf), .StallD(s_sd), .FlushE(s_fe),
    .StallCount(s_cnt)
`ifdef FWD_DECODE_EN
    , .ForwardAD(s_fad), .ForwardBD(s_fbd)
`endif
  );

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       rw, mr;
    logic [1:0] fa, fb;
    logic       st;
    int         cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input int rs, input int rt, input int wr, input int rw,
                              input int mr, input int fa, input int fb, input int st,
                              input int cnt);
    vec_t v;
    v.rs = rs[4:0]; v.rt = rt[4:0]; v.wr = wr[4:0];
    v.rw = rw[0];   v.mr = mr[0];
    v.fa = fa[1:0]; v.fb = fb[1:0];
    v.st = st[0];   v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int wr, input int rw,
                       input int mr, input int br);
    RsD = rs[4:0]; RtD = rt[4:0]; WriteRegD = wr[4:0];
    RegWriteD = rw[0]; MemtoRegD = mr[0]; BranchD = br[0];
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [1:0] fa,
                            input logic [1:0] fb, input logic st, input int cnt);
    int sat;
    sat = (cnt > 3) ? 3 : cnt;
    chk({tag, "_fwdA"}, idx, 32'(ForwardAE), 32'(fa));
    chk({tag, "_fwdB"}, idx, 32'(ForwardBE), 32'(fb));
    chk({tag, "_stallF"}, idx, 32'(StallF), 32'(st));
    chk({tag, "_stallD"}, idx, 32'(StallD), 32'(st));
    chk({tag, "_flushE"}, idx, 32'(FlushE), 32'(st));
    chk({tag, "_count"}, idx, 32'(StallCount), 32'(cnt));
    chk({tag, "_satcount"}, idx, 32'(s_cnt), 32'(sat));
  endtask

  initial begin
    // Each row: D-stage instruction, then outputs expected while it sits in D.
    tbl[0]  = mk( 1,  2,  3, 1, 0, 0, 0, 0, 0);  // add $3,$1,$2
    tbl[1]  = mk( 3,  5,  4, 1, 0, 0, 0, 0, 0);  // add $4,$3,$5
    tbl[2]  = mk( 0,  0,  0, 0, 0, 2, 0, 0, 0);  // $3 from M to operand A
    tbl[3]  = mk( 8,  9,  3, 1, 0, 0, 0, 0, 0);  // producer of $3
    tbl[4]  = mk(11, 12, 10, 1, 0, 0, 0, 0, 0);  // unrelated
    tbl[5]  = mk(14,  3, 13, 1, 0, 0, 0, 0, 0);  // consumer of $3 in Rt
    tbl[6]  = mk( 0,  0,  0, 0, 0, 0, 1, 0, 0);  // $3 from W to operand B
    tbl[7]  = mk( 1,  2,  0, 1, 0, 0, 0, 0, 0);  // writes $0
    tbl[8]  = mk( 0,  0,  5, 1, 0, 0, 0, 0, 0);  // reads $0,$0
    tbl[9]  = mk( 0,  0,  0, 0, 0, 0, 0, 0, 0);  // $0 never forwarded
    tbl[10] = mk( 1,  2,  2, 1, 1, 0, 0, 0, 0);  // lw $2,0($1)
    tbl[11] = mk( 2,  6,  7, 1, 0, 0, 0, 1, 0);  // add $7,$2,$6 -> stall
    tbl[12] = mk( 2,  6,  7, 1, 0, 0, 0, 0, 1);  // held, bubble in E
    tbl[13] = mk( 0,  0,  0, 0, 0, 1, 0, 0, 1);  // $2 from W
    tbl[14] = mk( 1,  1,  7, 1, 0, 0, 0, 0, 1);  // write $7
    tbl[15] = mk( 2,  2,  7, 1, 0, 0, 0, 0, 1);  // write $7 again
    tbl[16] = mk( 7,  7,  8, 1, 0, 0, 0, 0, 1);  // consumer of $7
    tbl[17] = mk( 0,  0,  0, 0, 0, 2, 2, 0, 1);  // M and W both hit, M wins
    tbl[18] = mk( 7,  9,  9, 1, 1, 0, 0, 0, 1);  // lw $9,0($7)
    tbl[19] = mk( 1,  9, 10, 1, 0, 0, 0, 1, 1);  // use $9 in Rt -> stall
    tbl[20] = mk( 1,  9, 10, 1, 0, 0, 0, 0, 2);  // held
    tbl[21] = mk( 0,  0,  0, 0, 0, 0, 1, 0, 2);  // $9 from W to B
    tbl[22] = mk( 1,  0,  0, 1, 1, 0, 0, 0, 2);  // lw $0
    tbl[23] = mk( 0,  0,  5, 1, 0, 0, 0, 0, 2);  // reads $0: no stall
    tbl[24] = mk( 0,  0,  0, 0, 0, 0, 0, 0, 2);

    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_outs("reset", 0, 2'b00, 2'b00, 1'b0, 0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].wr, tbl[i].rw, tbl[i].mr, 0);
      @(negedge CLK);
      check_outs("vec", i, tbl[i].fa, tbl[i].fb, tbl[i].st, tbl[i].cnt);
      @(posedge CLK);
      #1;
    end

    // Reset arriving during a load-use stall cycle
    drive(1, 2, 2, 1, 1, 0);
    @(posedge CLK); #1;
    drive(2, 6, 7, 1, 0, 0);
    @(negedge CLK);
    chk("rst_mid_stall_pre", 0, 32'(StallF), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_outs("rst_mid_stall", 1, 2'b00, 2'b00, 1'b0, 0);
    @(posedge CLK); #1;

    // Four separate load-use stalls: wide counter reaches 4, narrow one holds at 3
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, 2, 1, 1, 0);
      @(posedge CLK); #1;
      drive(2, 6, 7, 1, 0, 0);
      @(negedge CLK);
      chk("sat_stall_on", k, 32'(FlushE), 32'd1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("sat_stall_off", k, 32'(FlushE), 32'd0);
      chk("sat_count", k, 32'(StallCount), 32'(k + 1));
      chk("sat_narrow", k, 32'(s_cnt), 32'((k + 1 > 3) ? 3 : k + 1));
      @(posedge CLK); #1;
    end

`ifdef FWD_DECODE_EN
    // beq on the result of the immediately preceding add
    drive(0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    drive(1, 2, 3, 1, 0, 0);
    @(posedge CLK); #1;
    drive(3, 4, 0, 0, 0, 1);
    @(negedge CLK);
    chk("beq_stall", 0, 32'(StallD), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("beq_release", 1, 32'(StallD), 32'd0);
    chk("beq_fwdAD", 1, 32'(ForwardAD), 32'd1);
    chk("beq_fwdBD", 1, 32'(ForwardBD), 32'd0);
    @(posedge CLK); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
